// File: rtl/harmonic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : harmonic_sequencer
//  Purpose  : Per-sample controller for the harmonic scaling multiplier.
//             Reloads the multiplier on each sample tick, steps it once per
//             harmonic and strobes level/mute/index to the accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module harmonic_sequencer #(
    parameter int DIV_BIT    = 8,
    parameter int HARM_BITS  = 7,
    parameter int EARLY_STOP = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Sample_Tick,
    input  logic [HARM_BITS-1:0] i_Harm_Count,
    input  logic [DIV_BIT-1:0]   i_Mult,
    input  logic                 i_Mult_Ready,
    input  logic                 i_Comb_Muted,
    output logic                 o_Mult_Restart,
    output logic                 o_Mult_Start,
    output logic                 o_Harm_Valid,
    output logic [HARM_BITS-1:0] o_Harm_Index,
    output logic [DIV_BIT-1:0]   o_Harm_Level,
    output logic                 o_Harm_Mute,
    output logic                 o_Busy,
    output logic                 o_Frame_Done,
    output logic                 o_Overrun,
    output logic                 o_Timeout
);

    // WAIT counter only needs to reach TIMEOUT-1 before the abort fires
    localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EMIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [HARM_BITS-1:0] count_q, count_d;
    logic [HARM_BITS-1:0] index_q, index_d;
    logic [c_TMR_W-1:0]   timer_q, timer_d;
    logic                 restart_q, restart_d;
    logic                 start_q, start_d;
    logic                 valid_q, valid_d;
    logic [HARM_BITS-1:0] harm_index_q, harm_index_d;
    logic [DIV_BIT-1:0]   level_q, level_d;
    logic                 mute_q, mute_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;

    // Next-state and registered-output computation; pulses default low
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        timer_d      = timer_q;
        restart_d    = 1'b0;
        start_d      = 1'b0;
        valid_d      = 1'b0;
        harm_index_d = harm_index_q;
        level_d      = level_q;
        mute_d       = mute_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;

        // A tick outside IDLE is flagged and otherwise ignored
        if (i_Sample_Tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_Sample_Tick) begin
                    if (i_Harm_Count == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        count_d   = i_Harm_Count;
                        index_d   = '0;
                        restart_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if ((EARLY_STOP != 0) && (i_Mult == '0)) begin
                    state_d = S_DONE;
                end else begin
                    valid_d      = 1'b1;
                    level_d      = i_Mult;
                    mute_d       = i_Comb_Muted;
                    harm_index_d = index_q;
                    if (index_q == (count_q - HARM_BITS'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        start_d = 1'b1;
                        index_d = index_q + HARM_BITS'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_Mult_Ready) begin
                    state_d = S_EMIT;
                end else if (timer_q == c_TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + c_TMR_W'(1);
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything including pulses in flight
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            timer_q      <= '0;
            restart_q    <= 1'b0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            harm_index_q <= '0;
            level_q      <= '0;
            mute_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            timer_q      <= timer_d;
            restart_q    <= restart_d;
            start_q      <= start_d;
            valid_q      <= valid_d;
            harm_index_q <= harm_index_d;
            level_q      <= level_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_Mult_Restart = restart_q;
    assign o_Mult_Start   = start_q;
    assign o_Harm_Valid   = valid_q;
    assign o_Harm_Index   = harm_index_q;
    assign o_Harm_Level   = level_q;
    assign o_Harm_Mute    = mute_q;
    assign o_Busy         = busy_q;
    assign o_Frame_Done   = frame_done_q;
    assign o_Overrun      = overrun_q;
    assign o_Timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_harmonic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_harmonic_sequencer
//  Purpose  : Directed self-checking bench for harmonic_sequencer, driven by
//             a small behavioural model of the scaling multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_harmonic_sequencer;

    localparam int c_DW = 8;
    localparam int c_HW = 7;
    localparam int c_TO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic            sel_ns = 1'b0;
    logic [c_HW-1:0] hcount = '0;

    // multiplier model state
    logic [c_DW-1:0] m_level = '0;
    logic            m_mute = 1'b0;
    logic            m_ready = 1'b1;
    int              m_step = 0;
    int              m_busy = 0;
    logic            kill = 1'b0;
    logic            kill_arm = 1'b0;
    int              cfg_init = 0, cfg_scale = 0, cfg_comb = 0;

    // DUT A: EARLY_STOP=1, DUT B: EARLY_STOP=0
    logic a_restart, a_start, a_valid, a_mute, a_busy, a_done, a_ovr, a_to;
    logic b_restart, b_start, b_valid, b_mute, b_busy, b_done, b_ovr, b_to;
    logic [c_HW-1:0] a_idx, b_idx;
    logic [c_DW-1:0] a_lvl, b_lvl;
    logic tick_a, tick_b;
    assign tick_a = tick & ~sel_ns;
    assign tick_b = tick & sel_ns;

    harmonic_sequencer #(.DIV_BIT(c_DW), .HARM_BITS(c_HW), .EARLY_STOP(1), .TIMEOUT(c_TO)) u_dut (
        .i_Clock(clk), .i_Reset(rst), .i_Sample_Tick(tick_a), .i_Harm_Count(hcount),
        .i_Mult(m_level), .i_Mult_Ready(m_ready), .i_Comb_Muted(m_mute),
        .o_Mult_Restart(a_restart), .o_Mult_Start(a_start), .o_Harm_Valid(a_valid),
        .o_Harm_Index(a_idx), .o_Harm_Level(a_lvl), .o_Harm_Mute(a_mute),
        .o_Busy(a_busy), .o_Frame_Done(a_done), .o_Overrun(a_ovr), .o_Timeout(a_to));

    harmonic_sequencer #(.DIV_BIT(c_DW), .HARM_BITS(c_HW), .EARLY_STOP(0), .TIMEOUT(c_TO)) u_dut_ns (
        .i_Clock(clk), .i_Reset(rst), .i_Sample_Tick(tick_b), .i_Harm_Count(hcount),
        .i_Mult(m_level), .i_Mult_Ready(m_ready), .i_Comb_Muted(m_mute),
        .o_Mult_Restart(b_restart), .o_Mult_Start(b_start), .o_Harm_Valid(b_valid),
        .o_Harm_Index(b_idx), .o_Harm_Level(b_lvl), .o_Harm_Mute(b_mute),
        .o_Busy(b_busy), .o_Frame_Done(b_done), .o_Overrun(b_ovr), .o_Timeout(b_to));

    // outputs of whichever instance is under test
    logic s_restart, s_start, s_valid, s_mute, s_busy, s_done, s_ovr, s_to;
    logic [c_HW-1:0] s_idx;
    logic [c_DW-1:0] s_lvl;
    assign s_restart = sel_ns ? b_restart : a_restart;
    assign s_start   = sel_ns ? b_start   : a_start;
    assign s_valid   = sel_ns ? b_valid   : a_valid;
    assign s_mute    = sel_ns ? b_mute    : a_mute;
    assign s_busy    = sel_ns ? b_busy    : a_busy;
    assign s_done    = sel_ns ? b_done    : a_done;
    assign s_ovr     = sel_ns ? b_ovr     : a_ovr;
    assign s_to      = sel_ns ? b_to      : a_to;
    assign s_idx     = sel_ns ? b_idx     : a_idx;
    assign s_lvl     = sel_ns ? b_lvl     : a_lvl;

    always #5 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    int n_total = 0;
    int n_bad = 0;

    // event log, cycle numbers relative to the accepting edge (restart = cycle 1)
    int v_rel[$], v_lvl[$], v_idx[$], v_mute[$], fd_rel[$], to_rel[$];
    int ov_cnt = 0, rs_cnt = 0, busy_cnt = 0, viol = 0;
    logic prev_valid = 1'b0;

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // multiplier model: reload on restart, one saturating subtract per start,
    // ready back after 2 cycles (3 with comb), mute every (comb+1)-th step
    initial forever begin
        @(posedge clk);
        if (s_restart) begin
            m_level <= c_DW'(cfg_init);
            m_step  <= 0;
            m_mute  <= 1'b0;
            m_ready <= 1'b1;
            m_busy  <= 0;
            kill    <= 1'b0;
        end else if (s_start) begin
            m_level <= (int'(m_level) > cfg_scale) ? c_DW'(int'(m_level) - cfg_scale) : '0;
            m_step  <= m_step + 1;
            m_mute  <= (cfg_comb != 0) && (((m_step + 1) % (cfg_comb + 1)) == 0);
            m_ready <= 1'b0;
            m_busy  <= (cfg_comb != 0) ? 2 : 1;
            if (kill_arm) kill <= 1'b1;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1 && !kill) m_ready <= 1'b1;
        end
    end

    // monitor sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (s_valid === 1'b1) begin
            v_rel.push_back(cyc - t0 + 1);
            v_lvl.push_back(int'(s_lvl));
            v_idx.push_back(int'(s_idx));
            v_mute.push_back(int'(s_mute));
        end
        if (s_done === 1'b1)    fd_rel.push_back(cyc - t0 + 1);
        if (s_to === 1'b1)      to_rel.push_back(cyc - t0 + 1);
        if (s_ovr === 1'b1)     ov_cnt++;
        if (s_restart === 1'b1) rs_cnt++;
        if (s_busy === 1'b1)    busy_cnt++;
        if (s_restart === 1'b1 && s_start === 1'b1) viol++;
        if (s_valid === 1'b1 && prev_valid === 1'b1) viol++;
        prev_valid = s_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        v_rel.delete(); v_lvl.delete(); v_idx.delete(); v_mute.delete();
        fd_rel.delete(); to_rel.delete();
        ov_cnt = 0; rs_cnt = 0; busy_cnt = 0;
    endtask

    // issue one tick; returns in cycle 1 of the frame
    task automatic start_frame(input logic ns, input int count, input int init,
                               input int scale, input int comb);
        @(negedge clk);
        #1;
        clear_log();
        sel_ns    = ns;
        cfg_init  = init;
        cfg_scale = scale;
        cfg_comb  = comb;
        hcount    = c_HW'(count);
        tick      = 1'b1;
        @(posedge clk);
        #1;
        t0   = cyc;
        tick = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // compare logged valids against an arithmetic level ramp
    task automatic check_valids(input string tag, input int n, input int first_rel,
                                input int spacing, input int first_lvl, input int step_lvl,
                                input int mute_mask);
        int exp_lvl;
        check_eq({tag, "_nvalid"}, v_rel.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < v_rel.size()) begin
                exp_lvl = first_lvl - k * step_lvl;
                if (exp_lvl < 0) exp_lvl = 0;
                check_eq($sformatf("%s_rel%0d", tag, k), v_rel[k], first_rel + k * spacing);
                check_eq($sformatf("%s_lvl%0d", tag, k), v_lvl[k], exp_lvl);
                check_eq($sformatf("%s_idx%0d", tag, k), v_idx[k], k);
                check_eq($sformatf("%s_mute%0d", tag, k), v_mute[k], (mute_mask >> k) & 1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outs", 32'({a_restart, a_start, a_valid, a_mute, a_busy,
                                  a_done, a_ovr, a_to, a_idx, a_lvl}), 0);
        check_eq("rst_state", 32'(u_dut.state_q), 0);
        rst = 1'b0;

        // basic frame, early stop on zero level
        start_frame(1'b0, 8, 200, 50, 0);
        run(30);
        check_valids("t1", 4, 3, 4, 200, 50, 0);
        check_eq("t1_nfd", fd_rel.size(), 1);
        check_eq("t1_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 20);
        check_eq("t1_busy_after", 32'(a_busy), 0);
        check_eq("t1_nrestart", rs_cnt, 1);

        // comb muting, 5-cycle spacing
        start_frame(1'b0, 7, 255, 10, 2);
        run(45);
        check_valids("t2", 7, 3, 5, 255, 10, 32'h48);
        check_eq("t2_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 34);

        // count limit with EARLY_STOP=0
        start_frame(1'b1, 3, 20, 20, 0);
        run(20);
        check_valids("t3", 3, 3, 4, 20, 20, 0);
        check_eq("t3_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 12);

        // overrun: second tick in cycle 5 with a different count
        start_frame(1'b0, 8, 200, 10, 0);
        repeat (4) @(posedge clk);
        #1;
        tick   = 1'b1;
        hcount = c_HW'(2);
        @(posedge clk);
        #1;
        tick = 1'b0;
        run(40);
        check_eq("t4_overrun", ov_cnt, 1);
        check_valids("t4", 8, 3, 4, 200, 10, 0);
        check_eq("t4_nfd", fd_rel.size(), 1);
        check_eq("t4_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 32);
        check_eq("t4_nrestart", rs_cnt, 1);

        // zero count
        start_frame(1'b0, 0, 200, 10, 0);
        run(10);
        check_eq("t4b_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 1);
        check_eq("t4b_nfd", fd_rel.size(), 1);
        check_eq("t4b_nrestart", rs_cnt, 0);
        check_eq("t4b_busy", busy_cnt, 0);
        check_eq("t4b_nvalid", v_rel.size(), 0);

        // reset during WAIT of harmonic 2 (cycles 8-9)
        start_frame(1'b0, 8, 200, 50, 0);
        repeat (7) @(posedge clk);
        #1;
        check_eq("t5_in_wait", 32'(u_dut.state_q), 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t5_outs", 32'({a_restart, a_start, a_valid, a_mute, a_busy,
                                 a_done, a_ovr, a_to, a_idx, a_lvl}), 0);
        check_eq("t5_state", 32'(u_dut.state_q), 0);
        check_eq("t5_nvalid_pre", v_rel.size(), 2);
        run(5);
        check_eq("t5_nfd", fd_rel.size(), 0);
        start_frame(1'b0, 8, 200, 50, 0);
        run(25);
        check_valids("t5r", 4, 3, 4, 200, 50, 0);

        // timeout: ready never returns after the first start
        kill_arm = 1'b1;
        start_frame(1'b0, 4, 100, 10, 0);
        run(30);
        kill_arm = 1'b0;
        check_eq("t6_nvalid", v_rel.size(), 1);
        check_eq("t6_nto", to_rel.size(), 1);
        check_eq("t6_to_rel", (to_rel.size() > 0) ? to_rel[0] : -1, 19);
        check_eq("t6_fd_rel", (fd_rel.size() > 0) ? fd_rel[0] : -1, 20);

        check_eq("no_overlap", viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/harmonic_sequencer.md
# harmonic_sequencer

Per-sample controller for the harmonic scaling multiplier: on each sample tick it reloads the multiplier and then steps it through one attenuation per harmonic. After each step it captures the resulting level and comb-mute flag and presents them, with the harmonic index, to the additive-synthesis accumulator as a one-cycle valid strobe. It sits between the sample-rate timing generator and the scaling multiplier.

## Interface
Parameters:
- DIV_BIT, 8, width of the multiplier level
- HARM_BITS, 7, width of the harmonic index and count
- EARLY_STOP, 1, when 1 the frame ends at the first zero level
- TIMEOUT, 15, maximum cycles spent in WAIT before aborting

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Sample_Tick  in  1  one-cycle pulse that starts a frame
- i_Harm_Count  in  HARM_BITS  harmonics per frame, sampled on the accepted tick
- i_Mult  in  DIV_BIT  multiplier current level
- i_Mult_Ready  in  1  multiplier ready flag
- i_Comb_Muted  in  1  multiplier comb-mute flag
- o_Mult_Restart  out  1  one-cycle reload pulse to the multiplier
- o_Mult_Start  out  1  one-cycle step pulse to the multiplier
- o_Harm_Valid  out  1  one-cycle strobe: index, level and mute are valid
- o_Harm_Index  out  HARM_BITS  harmonic number, 0 = fundamental
- o_Harm_Level  out  DIV_BIT  captured level
- o_Harm_Mute  out  1  captured comb mute
- o_Busy  out  1  high from the accepted tick until o_Frame_Done
- o_Frame_Done  out  1  one-cycle end-of-frame pulse
- o_Overrun  out  1  one-cycle pulse: tick arrived while busy
- o_Timeout  out  1  one-cycle pulse: frame aborted in WAIT

## Operation
- All outputs are registered; every output resets to 0 and the state resets to IDLE.
- **IDLE**
  - On i_Sample_Tick with i_Harm_Count = 0: pulse o_Frame_Done next cycle; o_Busy stays 0.
  - On i_Sample_Tick with count > 0: latch count, clear the index, assert o_Mult_Restart and o_Busy, go to LOAD.
- **LOAD** (1 cycle): deassert o_Mult_Restart, go to EMIT.
- **EMIT** (1 cycle): i_Mult is valid in this cycle.
  - If EARLY_STOP = 1 and i_Mult = 0: go to DONE without emitting.
  - Otherwise register o_Harm_Valid=1, o_Harm_Level=i_Mult, o_Harm_Mute=i_Comb_Muted and o_Harm_Index=index.
  - If index = count−1, go to DONE. Otherwise assert o_Mult_Start, increment the index and go to ISSUE.
  - Harmonic 0 carries the unattenuated initial level and mute 0.
- **ISSUE** (1 cycle): deassert o_Mult_Start, clear the timeout counter, go to WAIT.
- **WAIT**: the multiplier has already dropped ready by this cycle.
  - When i_Mult_Ready = 1, go to EMIT.
  - Count cycles spent here; on reaching TIMEOUT, pulse o_Timeout and go to DONE.
- **DONE** (1 cycle): pulse o_Frame_Done, clear o_Busy, go to IDLE.
- i_Sample_Tick in any state other than IDLE: pulse o_Overrun, ignore the tick, and leave the current frame unaffected.
- The index never exceeds count−1, and no wrap is possible because the count is latched.
- i_Harm_Count changes during a frame have no effect.
- i_Reset in any state returns to IDLE on the next edge and clears all outputs, including any restart/start pulse in flight. A partial frame gives no o_Frame_Done.

## Timing
- Tick accepted at edge 0:
  - o_Mult_Restart is high in cycle 1 (LOAD).
  - EMIT for harmonic 0 is cycle 2.
  - o_Harm_Valid for harmonic 0 is high in cycle 3.
- Harmonic spacing is EMIT→ISSUE→WAIT→EMIT:
  - 4 cycles when the multiplier's comb path is off (ready returns 2 cycles after the start pulse).
  - 5 cycles when comb is enabled.
- Frame length for N harmonics with comb off: o_Frame_Done is high in cycle 4N.
- o_Mult_Restart and o_Mult_Start are never high in the same cycle. At most one of them is high per frame phase.
- o_Harm_Valid is never high in two consecutive cycles.

## Test plan
Tests 1–4 drive the real multiplier model.
- **Basic frame.** Initial 200, scale 50, comb interval 0, count 8, EARLY_STOP=1 → valids at cycles 3, 7, 11, 15 with levels 200, 150, 100, 50 and indices 0–3. The zero level stops the frame; o_Frame_Done high once, o_Busy low afterwards.
- **Comb muting.** Initial 255, scale 10, comb interval 2, count 7 → 7 valids spaced 5 cycles apart, levels 255, 245 … 195. Mute is 1 on indices 3 and 6 only.
- **Count limit and EARLY_STOP=0.** Count 3, initial 20, scale 20 → exactly 3 valids with levels 20, 0, 0, then o_Frame_Done.
- **Overrun.** Tick repeated 5 cycles into a count-8 frame → o_Overrun pulses once and the frame completes unchanged. Separately, count 0 → o_Frame_Done at cycle 1, no restart.
- **Reset mid-frame.** i_Reset asserted during WAIT of harmonic 2 → next cycle all outputs are 0 and the state is IDLE. A fresh tick then starts from index 0 with the initial level.
- **Timeout.** i_Mult_Ready forced to 0 after the first start pulse → o_Timeout pulses after TIMEOUT WAIT cycles, followed by o_Frame_Done; no further valids.
